// File: rtl/hud_pkg.sv
// Shared types and geometry constants for the lives HUD.
// Geometry is relative to the label's top-left corner.
package hud_pkg;

    typedef enum logic [1:0] {ALIVE, BLINK, OVER} hud_state_t;

    localparam int TEXT_W     = 48;
    localparam int TEXT_H     = 16;
    localparam int ICON_SIZE  = 8;
    localparam int ICON_PITCH = 12;
    localparam int ICON_X_OFF = 52;
    localparam int ICON_Y_OFF = 4;
    localparam int MAX_ICONS  = 7;

endpackage

// File: rtl/lives_fsm.sv
// Lives counter, post-hit invulnerability blink and game-over flag.
// Counts frames during BLINK; new_game overrides every other event.
module lives_fsm
    import hud_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       player_hit,
    input  logic       new_game,
    output logic [2:0] lives,
    output logic       blinking,
    output logic       game_over
);

    // Counter must have at least 4 bits since bit 3 drives the blink.
    localparam int CW = ($clog2(BLINK_FRAMES) > 4) ? $clog2(BLINK_FRAMES) : 4;
    localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);

    hud_state_t    state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ALIVE;
            lives_q <= LIVES_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        if (new_game) begin
            state_d = ALIVE;
            lives_d = LIVES_INIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ALIVE: begin
                    if (player_hit) begin
                        cnt_d = '0;
                        if (lives_q > 3'd1) begin
                            lives_d = lives_q - 3'd1;
                            state_d = BLINK;
                        end else begin
                            lives_d = 3'd0;
                            state_d = OVER;
                        end
                    end
                end
                BLINK: begin
                    if (frame_start) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ALIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                OVER: begin
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    assign lives     = lives_q;
    assign blinking  = (state_q == BLINK) && cnt_q[3];
    assign game_over = (state_q == OVER);

endmodule

// File: rtl/lives_hud.sv
// Lives HUD: two-stage raster pipeline driving the text map and
// the colour mapper, plus life icons right of the label.
module lives_hud
    import hud_pkg::*;
#(
    parameter int HUD_X0       = 8,
    parameter int HUD_Y0       = 8,
    parameter int START_LIVES  = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       player_hit,
    input  logic       new_game,
    output logic [5:0] text_X,
    output logic [3:0] text_Y,
    input  logic       text_pixel,
    output logic       hud_on,
    output logic       hud_is_icon,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam logic [9:0] LX0 = 10'(HUD_X0);
    localparam logic [9:0] LX1 = 10'(HUD_X0 + TEXT_W);
    localparam logic [9:0] LY0 = 10'(HUD_Y0);
    localparam logic [9:0] LY1 = 10'(HUD_Y0 + TEXT_H);
    localparam logic [9:0] IY0 = 10'(HUD_Y0 + ICON_Y_OFF);
    localparam logic [9:0] IY1 = 10'(HUD_Y0 + ICON_Y_OFF + ICON_SIZE);

    logic [2:0]           lives_w;
    logic                 blinking;
    logic                 in_label;
    logic                 in_icon_row;
    logic [MAX_ICONS-1:0] icon_hit;

    logic [5:0] text_x_q, text_x_d;
    logic [3:0] text_y_q, text_y_d;
    logic       label_q, label_d;
    logic       icon_q, icon_d;
    logic       hud_on_q, hud_on_d;
    logic       is_icon_q, is_icon_d;

    lives_fsm #(
        .START_LIVES (START_LIVES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_fsm (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .player_hit (player_hit),
        .new_game   (new_game),
        .lives      (lives_w),
        .blinking   (blinking),
        .game_over  (game_over)
    );

    assign in_label    = (DrawX >= LX0) && (DrawX < LX1) &&
                         (DrawY >= LY0) && (DrawY < LY1);
    assign in_icon_row = (DrawY >= IY0) && (DrawY < IY1);

    for (genvar i = 0; i < MAX_ICONS; i++) begin : g_icon
        localparam int X_LO = HUD_X0 + ICON_X_OFF + ICON_PITCH * i;
        localparam logic [9:0] IX0 = 10'(X_LO);
        localparam logic [9:0] IX1 = 10'(X_LO + ICON_SIZE);
        assign icon_hit[i] = (DrawX >= IX0) && (DrawX < IX1) &&
                             in_icon_row && (3'(i) < lives_w);
    end

    always_comb begin
        text_x_d  = '0;
        text_y_d  = '0;
        label_d   = in_label;
        icon_d    = (|icon_hit) && !blinking;
        if (in_label) begin
            text_x_d = 6'(DrawX - LX0);
            text_y_d = 4'(DrawY - LY0);
        end
        // Stage 2 combines the text map's answer with the stage-1 flags.
        hud_on_d  = (label_q && text_pixel) || icon_q;
        is_icon_d = icon_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            text_x_q  <= '0;
            text_y_q  <= '0;
            label_q   <= 1'b0;
            icon_q    <= 1'b0;
            hud_on_q  <= 1'b0;
            is_icon_q <= 1'b0;
        end else begin
            text_x_q  <= text_x_d;
            text_y_q  <= text_y_d;
            label_q   <= label_d;
            icon_q    <= icon_d;
            hud_on_q  <= hud_on_d;
            is_icon_q <= is_icon_d;
        end
    end

    assign text_X      = text_x_q;
    assign text_Y      = text_y_q;
    assign hud_on      = hud_on_q;
    assign hud_is_icon = is_icon_q;
    assign lives       = lives_w;

endmodule

// File: tb/tb_lives_hud.sv
// Self-checking bench for lives_hud against a behavioural model
// of the HUD geometry and the lives/blink rules.
module tb_lives_hud;

    localparam int X0 = 8;
    localparam int Y0 = 8;
    localparam int SL = 3;
    localparam int BF = 64;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic       player_hit;
    logic       new_game;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [5:0] text_X;
    logic [3:0] text_Y;
    logic       text_pixel;
    logic       hud_on;
    logic       hud_is_icon;
    logic [2:0] lives;
    logic       game_over;
    logic       tp_mode;

    int checks = 0;
    int errors = 0;

    int m_lives;
    bit m_blink;
    bit m_over;
    int m_frames;
    int e_tx, e_ty;
    bit e_lab, e_icon, e_on, e_isicon;

    lives_hud #(
        .HUD_X0(X0), .HUD_Y0(Y0),
        .START_LIVES(SL), .BLINK_FRAMES(BF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .player_hit (player_hit),
        .new_game   (new_game),
        .text_X     (text_X),
        .text_Y     (text_Y),
        .text_pixel (text_pixel),
        .hud_on     (hud_on),
        .hud_is_icon(hud_is_icon),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 Clk = ~Clk;

    // Stand-in for the text map: a fixed glyph-like pattern.
    function automatic bit tpix(int x, int y);
        if (!tp_mode) return 1'b1;
        return ((x % 3) == 0) ^ ((y % 5) == 1);
    endfunction

    always_comb text_pixel = tpix(int'(text_X), int'(text_Y));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit icon_expect(int x, int y);
        int d, k;
        if (m_over) return 1'b0;
        if (m_blink && ((m_frames / 8) % 2 == 1)) return 1'b0;
        if (y < Y0 + 4 || y >= Y0 + 12) return 1'b0;
        if (x < X0 + 52) return 1'b0;
        d = x - (X0 + 52);
        k = d / 12;
        return (d % 12 < 8) && (k < 7) && (k < m_lives);
    endfunction

    task automatic check_outputs(string tag);
        chk({tag, ":text_X"}, 32'(text_X), 32'(e_tx));
        chk({tag, ":text_Y"}, 32'(text_Y), 32'(e_ty));
        chk({tag, ":hud_on"}, 32'(hud_on), 32'(e_on));
        chk({tag, ":is_icon"}, 32'(hud_is_icon), 32'(e_isicon));
        chk({tag, ":lives"}, 32'(lives), 32'(m_lives));
        chk({tag, ":game_over"}, 32'(game_over), 32'(m_over));
    endtask

    task automatic model_reset();
        m_lives  = SL;
        m_blink  = 0;
        m_over   = 0;
        m_frames = 0;
        e_tx = 0; e_ty = 0;
        e_lab = 0; e_icon = 0; e_on = 0; e_isicon = 0;
    endtask

    task automatic step(string tag);
        int x, y;
        bit n_on, n_isicon, n_lab, n_icon;
        int n_tx, n_ty;
        x = int'(DrawX);
        y = int'(DrawY);
        n_on     = (e_lab && tpix(e_tx, e_ty)) || e_icon;
        n_isicon = e_icon;
        n_lab    = (x >= X0) && (x < X0 + 48) && (y >= Y0) && (y < Y0 + 16);
        n_tx     = n_lab ? (x - X0) % 64 : 0;
        n_ty     = n_lab ? (y - Y0) % 16 : 0;
        n_icon   = icon_expect(x, y);
        if (new_game) begin
            m_lives = SL; m_blink = 0; m_over = 0; m_frames = 0;
        end else if (!m_blink && !m_over && player_hit) begin
            m_frames = 0;
            if (m_lives > 1) begin
                m_lives--;
                m_blink = 1;
            end else begin
                m_lives = 0;
                m_over  = 1;
            end
        end else if (m_blink && frame_start) begin
            if (m_frames == BF - 1) m_blink = 0;
            else m_frames++;
        end
        @(posedge Clk);
        #1;
        e_on = n_on; e_isicon = n_isicon;
        e_lab = n_lab; e_icon = n_icon;
        e_tx = n_tx; e_ty = n_ty;
        check_outputs(tag);
        frame_start = 0;
        player_hit  = 0;
        new_game    = 0;
    endtask

    task automatic do_reset();
        #2;
        Reset = 1'b1;
        #1;
        chk("rst:text_X", 32'(text_X), 32'd0);
        chk("rst:text_Y", 32'(text_Y), 32'd0);
        chk("rst:hud_on", 32'(hud_on), 32'd0);
        chk("rst:is_icon", 32'(hud_is_icon), 32'd0);
        chk("rst:lives", 32'(lives), 32'(SL));
        chk("rst:game_over", 32'(game_over), 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic frames(int n, string tag);
        for (int f = 0; f < n; f++) begin
            frame_start = 1;
            step(tag);
        end
    endtask

    initial begin
        Reset = 0; frame_start = 0; player_hit = 0; new_game = 0;
        DrawX = 0; DrawY = 0; tp_mode = 0;
        do_reset();

        DrawX = 10'd8; DrawY = 10'd8;
        step("label_t1");
        DrawX = 10'd56;
        step("gap_t1");
        chk("label_on", 32'(hud_on), 32'd1);
        step("gap_t2");
        chk("gap_off", 32'(hud_on), 32'd0);

        DrawY = 10'd14;
        DrawX = 10'd60; step("ic0");
        DrawX = 10'd72; step("ic1");
        chk("icon0_on", 32'(hud_on), 32'd1);
        DrawX = 10'd84; step("ic2");
        DrawX = 10'd96; step("ic3");
        step("ic_f1");
        step("ic_f2");
        chk("icon3_absent", 32'(hud_on), 32'd0);

        DrawX = 10'd60;
        player_hit = 1; step("hit1");
        for (int f = 0; f < BF; f++) begin
            frame_start = 1;
            player_hit  = (f == 10);
            step("blink_fs");
            step("blink_a");
            step("blink_b");
        end
        step("alive_again");

        player_hit = 1; step("hit2");
        frames(BF, "blink2");
        player_hit = 1; step("hit_last");
        step("over");
        player_hit = 1; step("over_hit");
        step("over_a");
        step("over_b");

        new_game = 1; step("ng");
        player_hit = 1; step("ng_hit");
        frames(BF, "blink3");
        player_hit = 1; step("hit_to1");
        player_hit = 1; new_game = 1; step("ng_vs_hit");
        step("ng_after");

        player_hit = 1; step("pre_rst_hit");
        frames(30, "pre_rst");
        step("pre_rst_a");
        do_reset();
        player_hit = 1; step("post_rst_hit");
        for (int f = 0; f < 20; f++) begin
            frame_start = 1;
            step("post_fs");
            step("post_a");
            step("post_b");
        end

        tp_mode = 1;
        for (int n = 0; n < 4000; n++) begin
            DrawX       = 10'($urandom_range(0, 150));
            DrawY       = 10'($urandom_range(0, 25));
            frame_start = ($urandom_range(0, 3) == 0);
            player_hit  = ($urandom_range(0, 39) == 0);
            new_game    = ($urandom_range(0, 299) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lives_hud.md
# lives_hud

Sequential heads-up-display stage feeding the lives text map. Each clock it takes the VGA raster coordinate and does three things:
- Converts the coordinate into the text map's local X/Y.
- Samples the text map's returned pixel.
- Draws one life icon per remaining life to the right of the label.

It also owns the lives counter, the post-hit invulnerability blink and the game-over flag. Its output goes to the colour mapper.

## Interface
Parameters:
- HUD_X0, 8: screen X of the label's left edge.
- HUD_Y0, 8: screen Y of the label's top edge.
- START_LIVES, 3: lives loaded at reset and at new_game; range 1..7.
- BLINK_FRAMES, 64: length of the invulnerability window, in frames.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse once per frame at vertical blank.
- DrawX  in  10  current raster X.
- DrawY  in  10  current raster Y.
- player_hit  in  1  one-cycle pulse; the player was struck.
- new_game  in  1  one-cycle pulse; restart the game.
- text_X  out  6  local X to the text map; registered.
- text_Y  out  4  local Y to the text map; registered.
- text_pixel  in  1  text map output for text_X/text_Y; combinational from them.
- hud_on  out  1  the current pixel is HUD foreground.
- hud_is_icon  out  1  qualifies hud_on: 1 = icon pixel, 0 = label pixel.
- lives  out  3  remaining lives.
- game_over  out  1  high when lives reach 0.

## Operation
Geometry (unsigned 10-bit compares):
- Label region: HUD_X0 ≤ DrawX < HUD_X0+48 and HUD_Y0 ≤ DrawY < HUD_Y0+16.
- Inside the label region, text_X = DrawX−HUD_X0 and text_Y = DrawY−HUD_Y0, truncated to 6/4 bits.
- Outside the label region, text_X = 0 and text_Y = 0.
- Icon i (0..6) region: HUD_X0+52+12·i ≤ DrawX < HUD_X0+60+12·i and HUD_Y0+4 ≤ DrawY < HUD_Y0+12. Each icon is a solid 8×8 square.
- Icon i is drawn only if i < lives and icons are visible.
- Icons are visible unless state is BLINK and blink_cnt[3] = 1, so they toggle every 8 frames.
- Regions never overlap, so hud_on is the OR of the label term and the icon term.

State machine (states ALIVE, BLINK, OVER):
- Reset → ALIVE, lives = START_LIVES, blink_cnt = 0.
- new_game, in any state → ALIVE, lives = START_LIVES, blink_cnt = 0. It takes priority over a coincident player_hit.
- ALIVE + player_hit with lives > 1 → lives−1, go to BLINK, blink_cnt = 0.
- ALIVE + player_hit with lives = 1 → lives = 0, go to OVER.
- BLINK: blink_cnt increments on each frame_start.
  - When blink_cnt = BLINK_FRAMES−1 and frame_start arrives, go to ALIVE.
  - player_hit is ignored during BLINK.
- OVER: player_hit is ignored. game_over = 1. No icons are drawn.
- player_hit coincident with frame_start in ALIVE: the hit is applied, and the counter starts from 0.
- lives saturates at 0 and never wraps.

## Timing
- Raster pipeline, 2 cycles. DrawX/DrawY at cycle t gives text_X/text_Y registered at t+1.
- At t+1 the block samples text_pixel together with the registered label-region and icon-region flags.
- hud_on and hud_is_icon are registered at t+2.
- The downstream colour mapper delays DrawX/DrawY by 2 to match.
- Control: lives, state and game_over update on the clock edge after the pulse (1-cycle latency).
- The icon term uses the lives value as registered at stage 1.
- Reset values: text_X = 0, text_Y = 0, hud_on = 0, hud_is_icon = 0, lives = START_LIVES, game_over = 0, all pipeline flags = 0.
- Reset may be asserted mid-frame or mid-blink. It clears everything immediately (asynchronous) with no residual pulse.

## Structure
- Package hud_pkg holds:
  - typedef enum logic [1:0] {ALIVE, BLINK, OVER} hud_state_t
  - localparams TEXT_W=48, TEXT_H=16, ICON_SIZE=8, ICON_PITCH=12, ICON_X_OFF=52, ICON_Y_OFF=4
- Sub-module lives_fsm holds state, lives, blink_cnt and game_over, with ports Clk, Reset, frame_start, player_hit, new_game, lives, blinking, game_over.
- The top level holds the raster pipeline and a generate loop of 7 icon comparators. The lives text map is instantiated by the parent, not inside this block.

## Test plan
- Reset, then raster DrawX=8, DrawY=8 with text_pixel tied 1 → text_X=0 and text_Y=0 at t+1; hud_on=1 and hud_is_icon=0 at t+2. DrawX=56 (outside the label, in the 4 px gap before icon 0 at x=60) → hud_on=0.
- Lives=3, DrawY=14: DrawX=60, 72, 84 → hud_on=1, hud_is_icon=1. DrawX=96 → hud_on=0, because the 4th icon is absent.
- One player_hit → lives=2, state BLINK.
  - A second hit 10 frames later → lives stays 2.
  - Icon at DrawX=60 hidden during frames 8–15, visible during frames 0–7.
  - After 64 frame_start pulses → ALIVE.
- Hits at lives=1 → lives=0, game_over=1 one cycle later, no icons drawn. A further hit leaves lives=0 (no wrap).
- player_hit and new_game in the same cycle, from BLINK with lives=1 → lives=3, ALIVE, game_over=0.
- Assert Reset during BLINK with blink_cnt=30 → all outputs return to reset values at once. After release, the first hit restarts BLINK from blink_cnt=0.
